// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (shift-add) and restoring divide unit for the execute stage.
// One iteration per clock; result and exception are published with a one-cycle RDY pulse.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             ctrl_resetn,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_neg;
    logic               r_div_zero;
    logic               r_div_ovf;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;

    logic               w_start;
    logic               w_busy;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_fin_result;
    logic               w_fin_exc;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_busy  = (r_state == S_MULT) || (r_state == S_DIV);
    assign w_last  = (r_count == CNT_W'(WIDTH - 1));

    // Magnitudes: the most negative value maps to 2**(WIDTH-1), which still fits unsigned.
    assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply step: upper half accumulates the multiplicand, lower half shifts out the multiplier.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: upper half is the partial remainder, lower half turns into the quotient.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};
    assign w_div_acc   = w_div_trial[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod    = r_neg ? -w_mul_acc : w_mul_acc;
    assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quot    = r_neg ? -w_div_acc[WIDTH-1:0] : w_div_acc[WIDTH-1:0];

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_fin_result = w_prod[WIDTH-1:0];
        w_fin_exc    = w_mul_ovf;
        if (r_state == S_DIV) begin
            if (r_div_zero) begin
                w_fin_result = '0;
                w_fin_exc    = 1'b1;
            end else if (r_div_ovf) begin
                w_fin_result = {1'b1, {(WIDTH-1){1'b0}}};
                w_fin_exc    = 1'b1;
            end else begin
                w_fin_result = w_quot;
                w_fin_exc    = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (ctrl_MULT) begin
            w_state_next = S_MULT;
        end else if (ctrl_DIV) begin
            w_state_next = S_DIV;
        end else begin
            case (r_state)
                S_MULT, S_DIV: if (w_last) w_state_next = S_DONE;
                S_DONE:        w_state_next = S_IDLE;
                default:       w_state_next = r_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!ctrl_resetn) r_state <= S_IDLE;
        else              r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (!ctrl_resetn) begin
            r_count     <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_neg       <= 1'b0;
            r_div_zero  <= 1'b0;
            r_div_ovf   <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else if (w_start) begin
            // A start always recaptures, abandoning any operation in flight.
            r_count    <= '0;
            r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_div_zero <= (data_operandB == '0);
            r_div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
            if (ctrl_MULT) begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                r_opnd <= w_mag_a;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                r_opnd <= w_mag_b;
            end
        end else if (w_busy) begin
            r_acc   <= (r_state == S_MULT) ? w_mul_acc : w_div_acc;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
                r_result    <= w_fin_result;
                r_exception <= w_fin_exc;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = (r_state == S_DONE);
    assign busy           = w_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, multi-cycle corner sequences,
// and randomized operations compared against a plain-arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        ctrl_resetn;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .ctrl_resetn    (ctrl_resetn),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } ref_t;

    typedef struct {
        string       name;
        logic        is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic ref_t ref_model(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
        ref_t   r;
        longint p;
        if (is_mult) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            r.res = p[31:0];
            r.exc = (p != longint'($signed(p[31:0])));
        end else if (b == 32'h0) begin
            r.res = 32'h0;
            r.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.res = 32'h8000_0000;
            r.exc = 1'b1;
        end else begin
            r.res = $signed(a) / $signed(b);
            r.exc = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        int v;
        case ($urandom_range(5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: begin
                v = int'($urandom_range(40)) - 20;
                return v;
            end
            4: return $urandom >> $urandom_range(31);
            default: return $urandom;
        endcase
    endfunction

    // Launch from a negedge; lat counts rising edges after the capture edge until RDY is seen.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc, output int lat, output logic busy_ok);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        res     = '0;
        exc     = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = i;
                res = data_result;
                exc = data_exception;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] res;
        logic        exc;
        int          lat;
        logic        busy_ok;
        int          rdy_cnt;
        int          first_rdy;
        logic [31:0] first_res;
        ref_t        exp;
        logic        m;

        vecs[0] = '{"mul_3_m7",      1'b1, 32'd3,          32'hFFFF_FFF9, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{"mul_ovf_2p32",  1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2] = '{"mul_min_fit",   1'b1, 32'hFFFF_8000,  32'h0001_0000, 32'h8000_0000, 1'b0};
        vecs[3] = '{"mul_min_m1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[4] = '{"mul_zero",      1'b1, 32'h0,          32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[5] = '{"div_m7_2",      1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[6] = '{"div_100_m10",   1'b0, 32'd100,        32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0};
        vecs[7] = '{"div_by_zero",   1'b0, 32'd55,         32'h0,         32'h0000_0000, 1'b1};
        vecs[8] = '{"div_min_m1",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[9] = '{"div_7_m7",      1'b0, 32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};

        ctrl_resetn   = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_result", data_result, 32'h0);
        check("reset_exc",    data_exception, 1'b0);
        check("reset_rdy",    data_resultRDY, 1'b0);
        check("reset_busy",   busy, 1'b0);
        ctrl_resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_quiet", {data_resultRDY, busy}, 2'b00);

        // Directed table, launched back to back so each start also lands in the DONE cycle.
        foreach (vecs[k]) begin
            run_op(vecs[k].is_mult, ~vecs[k].is_mult, vecs[k].a, vecs[k].b, res, exc, lat, busy_ok);
            check({vecs[k].name, "_res"},  res, vecs[k].res);
            check({vecs[k].name, "_exc"},  exc, vecs[k].exc);
            check({vecs[k].name, "_lat"},  lat, 32);
            check({vecs[k].name, "_busy"}, busy_ok, 1'b1);
        end
        repeat (5) @(negedge clock);
        check("hold_result", data_result, 32'hFFFF_FFFF);
        check("hold_rdy_low", data_resultRDY, 1'b0);

        // Multiply abandoned at its 10th edge by a divide start.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd6;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        rdy_cnt   = 0;
        repeat (10) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd20;
        data_operandB = 32'd4;
        @(posedge clock);
        #1;
        ctrl_DIV  = 1'b0;
        first_rdy = -1;
        first_res = '0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                rdy_cnt++;
                if (first_rdy < 0) begin
                    first_rdy = i;
                    first_res = data_result;
                end
            end
        end
        check("restart_rdy_count", rdy_cnt, 1);
        check("restart_lat", first_rdy, 32);
        check("restart_res", first_res, 32'd5);

        // Simultaneous starts: multiply wins.
        run_op(1'b1, 1'b1, 32'd2, 32'd3, res, exc, lat, busy_ok);
        check("both_res", res, 32'd6);
        check("both_exc", exc, 1'b0);
        check("both_lat", lat, 32);

        // Reset in flight aborts the operation and clears the outputs.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        repeat (15) @(negedge clock);
        ctrl_resetn = 1'b0;
        @(negedge clock);
        check("abort_result", data_result, 32'h0);
        check("abort_exc",    data_exception, 1'b0);
        check("abort_busy",   busy, 1'b0);
        ctrl_resetn = 1'b1;
        rdy_cnt     = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        check("abort_no_rdy", rdy_cnt, 0);

        // Start held for three edges: latency counts from the last high edge.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'hFFFF_FFFE;
        repeat (3) @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        first_rdy = -1;
        first_res = '0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY && first_rdy < 0) begin
                first_rdy = i;
                first_res = data_result;
            end
        end
        check("held_lat", first_rdy, 32);
        check("held_res", first_res, 32'hFFFF_FFEE);

        // Randomized operations against the reference model.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a   = pick_operand();
            b   = pick_operand();
            m   = $urandom_range(1);
            exp = ref_model(m, a, b);
            repeat ($urandom_range(2)) @(negedge clock);
            run_op(m, ~m, a, b, res, exc, lat, busy_ok);
            check($sformatf("rand%0d_res", k), res, exp.res);
            check($sformatf("rand%0d_exc", k), exc, exp.exc);
            check($sformatf("rand%0d_lat", k), lat, 32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
